// File: rtl/dff_pipe_stage_chain_if.sv
// Handshake bundle for the elastic register chain.
// Carries the upstream (in_*) and downstream (out_*) valid/ready/data signals.
// The slave side is the chain itself; the master side is whatever surrounds it.
interface dff_pipe_stage_chain_if #(
   parameter int WIDTH = 8
);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;

   modport master (
      output in_valid,
      output in_data,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_data
   );

   modport slave (
      input  in_valid,
      input  in_data,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_data
   );

endinterface

// File: rtl/dff_pipe_stage_chain.sv
// Elastic delay line built from DEPTH register stages with valid/ready flow control.
// Each stage holds a valid bit and a data word. Words advance whenever the stage
// ahead is empty or is itself advancing, so bubbles collapse and a stalled chain
// fills up completely. Flush drops every word but leaves the data registers alone.
module dff_pipe_stage_chain #(
   parameter int               WIDTH     = 8,
   parameter int               DEPTH     = 4,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush,
   dff_pipe_stage_chain_if.slave      bus,
   output logic [$clog2(DEPTH+1)-1:0] occupancy
);

   localparam int OCCW = $clog2(DEPTH + 1);

   logic [DEPTH-1:0] vld;
   logic [WIDTH-1:0] data_q [DEPTH];

   logic [DEPTH-1:0] rdy;
   logic [DEPTH-1:0] src_vld;
   logic [WIDTH-1:0] src_data [DEPTH];

   logic             in_ready_int;
   logic             in_fire;
   logic             out_fire;
   logic [OCCW-1:0]  occupancy_next;

   // Ready ripples from the output back toward stage 0: a stage can load if it is
   // empty or if the stage in front of it is loading this cycle.
   always_comb begin
      logic acc;
      rdy = '0;
      acc = bus.out_ready;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         acc    = ~vld[i] | acc;
         rdy[i] = acc;
      end
   end

   // Each stage takes its source from the stage behind it; stage 0 takes the input port.
   always_comb begin
      src_vld     = '0;
      src_vld[0]  = bus.in_valid;
      src_data[0] = bus.in_data;
      for (int i = 1; i < DEPTH; i++) begin
         src_vld[i]  = vld[i-1];
         src_data[i] = data_q[i-1];
      end
   end

   assign in_ready_int  = rdy[0] & ~flush;
   assign in_fire       = bus.in_valid & in_ready_int;
   assign out_fire      = vld[DEPTH-1] & bus.out_ready;

   assign bus.in_ready  = in_ready_int;
   assign bus.out_valid = vld[DEPTH-1];
   assign bus.out_data  = data_q[DEPTH-1];

   // Occupancy moves by at most one per cycle; accept and deliver together cancel out.
   always_comb begin
      occupancy_next = occupancy;
      case ({in_fire, out_fire})
         2'b10:   occupancy_next = occupancy + OCCW'(1);
         2'b01:   occupancy_next = occupancy - OCCW'(1);
         default: occupancy_next = occupancy;
      endcase
   end

   // Valid bits: reset and flush empty the chain, otherwise a loading stage copies its source valid.
   always_ff @(posedge clk) begin
      if (reset) begin
         vld <= '0;
      end else if (flush) begin
         vld <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (rdy[i]) begin
               vld[i] <= src_vld[i];
            end
         end
      end
   end

   // Data registers only capture real words, so a bubble never overwrites the last value held.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            data_q[i] <= RESET_VAL;
         end
      end else if (!flush) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (rdy[i] && src_vld[i]) begin
               data_q[i] <= src_data[i];
            end
         end
      end
   end

   // Registered count of valid stages, cleared together with the valid bits.
   always_ff @(posedge clk) begin
      if (reset) begin
         occupancy <= '0;
      end else if (flush) begin
         occupancy <= '0;
      end else begin
         occupancy <= occupancy_next;
      end
   end

endmodule

// File: tb/tb_dff_pipe_stage_chain.sv
// Self-checking bench for the elastic register chain.
// Two builds run side by side: DEPTH=4/RESET_VAL=00 and DEPTH=1/RESET_VAL=A5.
// A word-level model tracks which stage each accepted word sits in and predicts
// in_ready, out_valid, out_data and occupancy every cycle.
module tb_dff_pipe_stage_chain;

   logic       clk = 1'b0;
   logic       reset;
   logic       flush4;
   logic       flush1;
   logic [2:0] occ4;
   logic [0:0] occ1;

   dff_pipe_stage_chain_if #(.WIDTH(8)) bus4 ();
   dff_pipe_stage_chain_if #(.WIDTH(8)) bus1 ();

   dff_pipe_stage_chain #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h00)) dut4 (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush4),
      .bus       (bus4),
      .occupancy (occ4)
   );

   dff_pipe_stage_chain #(.WIDTH(8), .DEPTH(1), .RESET_VAL(8'hA5)) dut1 (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush1),
      .bus       (bus1),
      .occupancy (occ1)
   );

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   int checks  = 0;
   int fails   = 0;
   int cycleNo = 0;

   // Model state per build: word list ordered oldest first, with stage position and data.
   int         mPos  [2][8];
   logic [7:0] mData [2][8];
   int         mCnt  [2];
   logic [7:0] mLast [2];
   int         mDepth[2];
   logic [7:0] mRv   [2];

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         fails++;
         $display("[TB] FAIL %s at cycle %0d: observed %0h expected %0h", tag, cycleNo, observed, expected);
      end
   endtask

   function automatic logic expInReady(input int k, input logic f, input logic r);
      return !f && ((mCnt[k] < mDepth[k]) || r);
   endfunction

   function automatic logic expOutValid(input int k);
      return (mCnt[k] > 0) && (mPos[k][0] == mDepth[k] - 1);
   endfunction

   // Advance the model by one clock edge using the inputs that were applied.
   task automatic modelStep(input int k, input logic rst, input logic f, input logic iv,
                            input logic [7:0] d, input logic r);
      int   dep;
      int   lim;
      int   np;
      logic inF;
      logic outF;
      dep = mDepth[k];
      if (rst) begin
         mCnt[k]  = 0;
         mLast[k] = mRv[k];
      end else if (f) begin
         mCnt[k] = 0;
      end else begin
         inF  = iv && ((mCnt[k] < dep) || r);
         outF = expOutValid(k) && r;
         if (outF) begin
            for (int i = 0; i < mCnt[k] - 1; i++) begin
               mPos[k][i]  = mPos[k][i+1];
               mData[k][i] = mData[k][i+1];
            end
            mCnt[k]--;
         end
         lim = dep;
         for (int i = 0; i < mCnt[k]; i++) begin
            np = mPos[k][i] + 1;
            if (np > lim - 1) np = lim - 1;
            mPos[k][i] = np;
            if (np == dep - 1) mLast[k] = mData[k][i];
            lim = np;
         end
         if (inF) begin
            mPos[k][mCnt[k]]  = 0;
            mData[k][mCnt[k]] = d;
            mCnt[k]++;
            if (dep == 1) mLast[k] = d;
         end
      end
   endtask

   // One clock cycle: drive both builds, compare against the model, then clock the model.
   task automatic applyStimulus(input bit doCheck, input logic rst,
                                input logic f4, input logic iv4, input logic [7:0] d4, input logic r4,
                                input logic f1, input logic iv1, input logic [7:0] d1, input logic r1);
      reset          = rst;
      flush4         = f4;
      bus4.in_valid  = iv4;
      bus4.in_data   = d4;
      bus4.out_ready = r4;
      flush1         = f1;
      bus1.in_valid  = iv1;
      bus1.in_data   = d1;
      bus1.out_ready = r1;
      #1;
      if (doCheck) begin
         checkOutput("d4_in_ready",  {31'd0, bus4.in_ready},  {31'd0, expInReady(0, f4, r4)});
         checkOutput("d4_out_valid", {31'd0, bus4.out_valid}, {31'd0, expOutValid(0)});
         checkOutput("d4_out_data",  {24'd0, bus4.out_data},  {24'd0, mLast[0]});
         checkOutput("d4_occupancy", {29'd0, occ4},           mCnt[0]);
         checkOutput("d1_in_ready",  {31'd0, bus1.in_ready},  {31'd0, expInReady(1, f1, r1)});
         checkOutput("d1_out_valid", {31'd0, bus1.out_valid}, {31'd0, expOutValid(1)});
         checkOutput("d1_out_data",  {24'd0, bus1.out_data},  {24'd0, mLast[1]});
         checkOutput("d1_occupancy", {31'd0, occ1},           mCnt[1]);
      end
      @(posedge clk);
      modelStep(0, rst, f4, iv4, d4, r4);
      modelStep(1, rst, f1, iv1, d1, r1);
      cycleNo++;
      @(negedge clk);
   endtask

   // Drive the DEPTH=4 build deliberately while the DEPTH=1 build sees random traffic.
   task automatic drive4(input logic rst, input logic f4, input logic iv4, input logic [7:0] d4, input logic r4);
      applyStimulus(1'b1, rst, f4, iv4, d4, r4,
                    ($urandom_range(0, 15) == 0), 1'($urandom), 8'($urandom), 1'($urandom));
   endtask

   // Drive the DEPTH=1 build deliberately while the DEPTH=4 build stays idle and draining.
   task automatic drive1(input logic iv1, input logic [7:0] d1, input logic r1);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, iv1, d1, r1);
   endtask

   // Hard stop in case the sequence ever stalls.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main sequence: directed scenarios followed by a randomized soak.
   initial begin
      mDepth[0] = 4;
      mDepth[1] = 1;
      mRv[0]    = 8'h00;
      mRv[1]    = 8'hA5;
      mCnt[0]   = 0;
      mCnt[1]   = 0;
      mLast[0]  = 8'h00;
      mLast[1]  = 8'hA5;
      reset     = 1'b1;
      flush4    = 1'b0;
      flush1    = 1'b0;
      bus4.in_valid = 1'b0; bus4.in_data = 8'h00; bus4.out_ready = 1'b0;
      bus1.in_valid = 1'b0; bus1.in_data = 8'h00; bus1.out_ready = 1'b0;
      @(negedge clk);

      $display("[TB] reset with random inputs");
      applyStimulus(1'b0, 1'b1, 1'($urandom), 1'($urandom), 8'($urandom), 1'($urandom),
                    1'($urandom), 1'($urandom), 8'($urandom), 1'($urandom));
      applyStimulus(1'b1, 1'b1, 1'b0, 1'($urandom), 8'($urandom), 1'($urandom),
                    1'b0, 1'($urandom), 8'($urandom), 1'($urandom));
      checkOutput("rst_out_valid", {31'd0, bus4.out_valid}, 32'd0);
      checkOutput("rst_out_data",  {24'd0, bus4.out_data},  32'h00);
      checkOutput("rst_occupancy", {29'd0, occ4},           32'd0);
      checkOutput("rst_d1_data",   {24'd0, bus1.out_data},  32'hA5);

      $display("[TB] streaming with out_ready held high");
      for (int i = 1; i <= 8; i++) drive4(1'b0, 1'b0, 1'b1, 8'(i), 1'b1);
      for (int i = 0; i < 6; i++)  drive4(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

      $display("[TB] fill while stalled, then drain");
      for (int i = 1; i <= 4; i++) drive4(1'b0, 1'b0, 1'b1, 8'hA0 + 8'(i), 1'b0);
      drive4(1'b0, 1'b0, 1'b1, 8'hA5, 1'b0);
      drive4(1'b0, 1'b0, 1'b1, 8'hA5, 1'b0);
      checkOutput("full_occupancy", {29'd0, occ4}, 32'd4);
      drive4(1'b0, 1'b0, 1'b1, 8'hA5, 1'b1);
      for (int i = 0; i < 7; i++) drive4(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

      $display("[TB] gapped input collapses while stalled");
      drive4(1'b0, 1'b0, 1'b1, 8'hA1, 1'b0);
      drive4(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      drive4(1'b0, 1'b0, 1'b1, 8'hA2, 1'b0);
      for (int i = 0; i < 4; i++) drive4(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      checkOutput("gap_occupancy", {29'd0, occ4},          32'd2);
      checkOutput("gap_out_data",  {24'd0, bus4.out_data}, 32'hA1);
      for (int i = 0; i < 5; i++) drive4(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

      $display("[TB] flush with three words in flight");
      for (int i = 1; i <= 3; i++) drive4(1'b0, 1'b0, 1'b1, 8'hC0 + 8'(i), 1'b0);
      drive4(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      drive4(1'b0, 1'b1, 1'b1, 8'hB0, 1'b1);
      checkOutput("flush_out_valid", {31'd0, bus4.out_valid}, 32'd0);
      checkOutput("flush_occupancy", {29'd0, occ4},           32'd0);
      for (int i = 0; i < 6; i++) drive4(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

      $display("[TB] reset mid-stream on a full chain with flush");
      for (int i = 1; i <= 4; i++) drive4(1'b0, 1'b0, 1'b1, 8'hD0 + 8'(i), 1'b0);
      drive4(1'b1, 1'b1, 1'b1, 8'hEE, 1'($urandom));
      checkOutput("mid_rst_out_valid", {31'd0, bus4.out_valid}, 32'd0);
      checkOutput("mid_rst_out_data",  {24'd0, bus4.out_data},  32'h00);
      checkOutput("mid_rst_occupancy", {29'd0, occ4},           32'd0);
      checkOutput("mid_rst_d1_data",   {24'd0, bus1.out_data},  32'hA5);

      $display("[TB] single-stage build handshake");
      drive1(1'b1, 8'h3C, 1'b0);
      checkOutput("d1_latency_valid", {31'd0, bus1.out_valid}, 32'd1);
      checkOutput("d1_latency_data",  {24'd0, bus1.out_data},  32'h3C);
      drive1(1'b1, 8'h4D, 1'b0);
      drive1(1'b1, 8'h4D, 1'b1);
      drive1(1'b0, 8'h00, 1'b1);
      drive1(1'b0, 8'h00, 1'b0);

      $display("[TB] randomized soak");
      for (int i = 0; i < 600; i++) begin
         applyStimulus(1'b1, ($urandom_range(0, 99) == 0),
                       ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 7), 8'($urandom),
                       ($urandom_range(0, 9) < 6),
                       ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 7), 8'($urandom),
                       ($urandom_range(0, 9) < 5));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
      $finish;
   end

endmodule
